// File: rtl/lc3_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : lc3_mem_arbiter
// Description : Shares one LC-3 memory port between the fetch and data
//               requesters, using round-robin grants and an access timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lc3_mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_complete,
    output logic          busy,
    output logic          owner
);

    localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic            prio_q,      prio_d;
    logic            owner_q,     owner_d;
    logic            mem_en_q,    mem_en_d;
    logic            mem_we_q,    mem_we_d;
    logic [AW-1:0]   mem_addr_q,  mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   rdata_q,     rdata_d;
    logic            err_q,       err_d;
    logic            if_done_q,   if_done_d;
    logic            d_done_q,    d_done_d;
    logic            busy_q,      busy_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic w_grant_data;
    logic w_timeout;

    // prio_q = 1 means the data side wins a tie
    assign w_grant_data = d_req & (~if_req | prio_q);
    assign w_timeout    = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b1;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        busy_d      = busy_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    owner_d     = w_grant_data;
                    mem_addr_d  = w_grant_data ? d_addr : if_addr;
                    mem_we_d    = w_grant_data & d_we;
                    mem_wdata_d = w_grant_data ? d_wdata : '0;
                    mem_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    prio_d      = ~w_grant_data;
                    cnt_d       = '0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // A completion on the timeout cycle still counts as success
                if (mem_complete) begin
                    rdata_d   = mem_rdata;
                    err_d     = 1'b0;
                    mem_en_d  = 1'b0;
                    if_done_d = ~owner_q;
                    d_done_d  = owner_q;
                    state_d   = S_RESP;
                end else if (w_timeout) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    mem_en_d  = 1'b0;
                    if_done_d = ~owner_q;
                    d_done_d  = owner_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_lc3_mem_arbiter
// Description : Directed self-checking bench for lc3_mem_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done;
    logic [15:0] rdata;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_complete = 1'b0;
    logic        busy;
    logic        owner;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_mem_arbiter #(.TIMEOUT(16), .AW(16), .DW(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_done       (d_done),
        .rdata        (rdata),
        .err          (err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_complete (mem_complete),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_en(input string tag);
        int n;
        n = 0;
        while (!mem_en && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_grant_seen"}, {31'd0, mem_en}, 32'd1);
    endtask

    initial begin
        int cnt;
        int busy_cycles;
        logic exp_owner;

        // Reset state
        #2;
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_outs",   {if_done, d_done, err, owner, mem_we, rdata, mem_addr[10:0]}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Single fetch
        if_req  = 1'b1;
        if_addr = 16'h3000;
        tick();
        check("f_mem_en",   {31'd0, mem_en}, 32'd1);
        check("f_mem_we",   {31'd0, mem_we}, 32'd0);
        check("f_mem_addr", {16'd0, mem_addr}, 32'h3000);
        check("f_owner",    {31'd0, owner}, 32'd0);
        mem_complete = 1'b1;
        mem_rdata    = 16'h1234;
        tick();
        check("f_if_done",  {31'd0, if_done}, 32'd1);
        check("f_d_done",   {31'd0, d_done}, 32'd0);
        check("f_rdata",    {16'd0, rdata}, 32'h1234);
        check("f_err",      {31'd0, err}, 32'd0);
        if_req       = 1'b0;
        mem_complete = 1'b0;
        tick();
        check("f_done_pulse", {30'd0, if_done, d_done}, 32'd0);
        check("f_busy_off",   {31'd0, busy}, 32'd0);

        // Data store, completes after 5 cycles of mem_en
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h4000;
        d_wdata = 16'hBEEF;
        tick();
        busy_cycles = 0;
        for (int i = 1; i <= 5; i++) begin
            check("st_mem_en",    {31'd0, mem_en}, 32'd1);
            check("st_mem_we",    {31'd0, mem_we}, 32'd1);
            check("st_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
            check("st_mem_addr",  {16'd0, mem_addr}, 32'h4000);
            if (busy) busy_cycles++;
            if (i == 5) begin
                mem_complete = 1'b1;
                mem_rdata    = 16'h5555;
            end
            tick();
        end
        check("st_d_done",  {31'd0, d_done}, 32'd1);
        check("st_if_done", {31'd0, if_done}, 32'd0);
        if (busy) busy_cycles++;
        d_req        = 1'b0;
        mem_complete = 1'b0;
        tick();
        if (busy) busy_cycles++;
        check("st_busy_cycles", busy_cycles, 32'd6);
        check("st_d_done_pulse", {31'd0, d_done}, 32'd0);

        // Dual requests held from reset: D, F, D, F
        rst_n   = 1'b0;
        #1;
        if_req  = 1'b1;
        if_addr = 16'h3010;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h4010;
        mem_complete = 1'b1;
        mem_rdata    = 16'h0777;
        tick();
        rst_n = 1'b1;
        exp_owner = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_mem_en("rr");
            check("rr_owner", {31'd0, owner}, {31'd0, exp_owner});
            check("rr_addr",  {16'd0, mem_addr}, exp_owner ? 32'h4010 : 32'h3010);
            tick();
            check("rr_done",  {30'd0, d_done, if_done}, exp_owner ? 32'd2 : 32'd1);
            tick();
            exp_owner = ~exp_owner;
        end
        if_req       = 1'b0;
        d_req        = 1'b0;
        mem_complete = 1'b0;
        tick();
        tick();

        // Timeout with no completion
        if_req  = 1'b1;
        if_addr = 16'h5000;
        tick();
        cnt = 0;
        while (mem_en && cnt < 40) begin
            cnt++;
            tick();
        end
        check("to_mem_en_cycles", cnt, 32'd16);
        check("to_if_done", {31'd0, if_done}, 32'd1);
        check("to_err",     {31'd0, err}, 32'd1);
        check("to_rdata",   {16'd0, rdata}, 32'h0000);
        if_req = 1'b0;
        tick();
        check("to_err_clear", {31'd0, err}, 32'd0);
        tick();
        mem_complete = 1'b1;
        mem_rdata    = 16'h9999;
        tick();
        check("late_no_done", {30'd0, if_done, d_done}, 32'd0);
        tick();
        check("late_idle",    {30'd0, busy, mem_en}, 32'd0);
        check("late_no_done2", {30'd0, if_done, d_done}, 32'd0);
        mem_complete = 1'b0;

        // Completion exactly on the timeout cycle
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h6000;
        tick();
        for (int i = 1; i <= 15; i++) tick();
        check("edge_mem_en", {31'd0, mem_en}, 32'd1);
        mem_complete = 1'b1;
        mem_rdata    = 16'hABCD;
        tick();
        check("edge_d_done", {31'd0, d_done}, 32'd1);
        check("edge_err",    {31'd0, err}, 32'd0);
        check("edge_rdata",  {16'd0, rdata}, 32'hABCD);
        d_req        = 1'b0;
        mem_complete = 1'b0;
        tick();
        tick();

        // Asynchronous reset mid-access
        if_req  = 1'b1;
        if_addr = 16'h7000;
        tick();
        check("ar_mem_en_pre", {31'd0, mem_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_mem_en", {31'd0, mem_en}, 32'd0);
        check("ar_busy",   {31'd0, busy}, 32'd0);
        check("ar_done",   {30'd0, if_done, d_done}, 32'd0);
        d_req  = 1'b1;
        d_addr = 16'h7100;
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_tie_owner", {31'd0, owner}, 32'd1);
        check("ar_tie_addr",  {16'd0, mem_addr}, 32'h7100);
        check("ar_no_stale_done", {31'd0, if_done}, 32'd0);
        if_req = 1'b0;
        mem_complete = 1'b1;
        mem_rdata    = 16'h0042;
        tick();
        check("ar_d_done", {31'd0, d_done}, 32'd1);
        check("ar_rdata",  {16'd0, rdata}, 32'h0042);
        d_req        = 1'b0;
        mem_complete = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Shares the LC-3 core's single memory port between the instruction-fetch requester and the data-access requester. Data accesses come from LD, ST, LDR, STR, LDI and STI; indirect ops issue two accesses themselves. The block sits between the core datapath and memory, and is what the bench's memory transactions and driver exercise:
- round-robin arbitration on simultaneous requests;
- sequencing of each access over a variable-latency complete handshake;
- timeout and error reporting when memory never completes.

## Interface
- TIMEOUT, 16: max cycles in ACCESS without mem_complete before abort; 0 disables the timeout.
- AW, 16: address width.
- DW, 16: data width.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  AW  fetch address, stable while if_req.
- if_done  out  1  one-cycle pulse: fetch access finished.
- d_req  in  1  data request, level; held until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  AW  data address, stable while d_req.
- d_wdata  in  DW  store data, stable while d_req.
- d_done  out  1  one-cycle pulse: data access finished.
- rdata  out  DW  read data, shared by both requesters; valid while the matching done is high.
- err  out  1  high with done when the access timed out.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid with mem_complete.
- mem_complete  in  1  memory finished the current access.
- busy  out  1  high in ACCESS or RESP.
- owner  out  1  current or last grant: 0 = fetch, 1 = data.

## Operation
States are IDLE, ACCESS and RESP. Reset values, all outputs registered:
- state IDLE, all outputs 0, timeout counter 0;
- prio = 1, so the data requester wins the first tie.

IDLE:
- If exactly one request is high, grant it.
- If both are high, grant the side indicated by prio.
- On a grant:
  - latch owner, address, we (fetch forces we=0) and wdata into the mem_* registers;
  - set mem_en=1;
  - flip prio to the non-granted side;
  - clear the counter;
  - go to ACCESS.
- With no request, stay in IDLE.

ACCESS:
- mem_en and the mem_* outputs stay stable.
- The counter increments each cycle.
- If mem_complete=1: register rdata = mem_rdata, err=0, mem_en=0, go to RESP.
- Else, if TIMEOUT≠0 and the counter reaches TIMEOUT-1: register rdata=0, err=1, mem_en=0, go to RESP.
- If both conditions hold in the same cycle, mem_complete wins.

RESP:
- Pulse if_done or d_done per owner for exactly one cycle; rdata and err are valid for that cycle.
- Next state is IDLE unconditionally.
- err and the done pulses clear on exit. rdata holds its value until the next RESP.

General rules:
- Requests are sampled only in IDLE. A requester may keep its req high straight after done to issue its next access.
- mem_complete is ignored in IDLE and RESP, including a late completion arriving after a timeout.
- rdata is updated on stores too, taking mem_rdata as-is; requesters ignore it for stores.
- Async reset mid-access immediately forces IDLE and zeroes all outputs, including mem_en. The aborted access gets no done pulse.

## Timing
- Request seen high at edge N gives mem_en=1 after edge N.
- mem_complete sampled at edge N+k (k≥1) gives done=1 after edge N+k, low after edge N+k+1.
- Minimum request-to-done latency is 2 cycles. Minimum back-to-back issue interval is 3 cycles (ACCESS, RESP, IDLE).
- Timeout: with no mem_complete, done+err assert after edge N+TIMEOUT, giving TIMEOUT cycles of mem_en=1.
- Under continuous dual requests, grants strictly alternate; neither requester waits more than one access.

## Test plan
- Single fetch, if_addr=16'h3000, mem_complete 1 cycle after mem_en, mem_rdata=16'h1234 -> mem_we=0, mem_addr=16'h3000, if_done one cycle with rdata=16'h1234, err=0, d_done never high.
- Data store, d_we=1, d_addr=16'h4000, d_wdata=16'hBEEF, complete after 5 cycles -> mem_we=1, mem_wdata=16'hBEEF held all 5 cycles, d_done one pulse, busy high 6 cycles.
- Both requesters hold req continuously from reset -> grant order D, F, D, F, …; owner toggles each access, no starvation.
- TIMEOUT=16, memory never completes -> mem_en high exactly 16 cycles, then done with err=1 and rdata=0. A mem_complete arriving 3 cycles later is ignored: no second done, and the state stays IDLE.
- mem_complete arrives exactly on the timeout cycle -> normal completion, err=0, rdata=mem_rdata.
- rst_n dropped during ACCESS -> mem_en, busy and done are 0 immediately. After release, state is IDLE and prio=1: a tie grants data first.
